// File: rtl/MIPS_pkg.sv
// Shared MIPS definitions: opcode field values, main-control state encoding,
// and the select/opcode encodings consumed by the ALU decoder and datapath.
package MIPS_pkg;

    // Opcode field (instr[31:26]) values the multi-cycle core supports.
    typedef enum logic [5:0] {
        MIPS_RTYPE_OP = 6'h00,
        MIPS_J_OP     = 6'h02,
        MIPS_BEQ_OP   = 6'h04,
        MIPS_ADDI_OP  = 6'h08,
        MIPS_LW_OP    = 6'h23,
        MIPS_SW_OP    = 6'h2B
    } mips_opcode_e;

    // Main control states. Encodings 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } ctrl_state_e;

    // ALUOp handed to the ALU decoder.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select.
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_main_ctrl_fsm.sv
// Main control unit of the multi-cycle MIPS core. Moore FSM walking
// fetch/decode/execute/memory/writeback; outputs decode from the state only
// (plus mem_ready/zero qualifying the PC and IR enables). The write enables
// are gated by rst_n so nothing is written while the core is held in reset.
module mips_main_ctrl_fsm
    import MIPS_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_e      r_state;
    ctrl_state_e      w_next_state;
    logic [CNT_W-1:0] r_instr_count;

    // Raw enables from the state decode, before reset gating.
    logic w_mem_write;
    logic w_ir_write;
    logic w_reg_write;
    logic w_pc_write_int;
    logic w_branch_int;
    logic w_illegal_op;

    // State register; reset returns to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:    w_next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    MIPS_LW_OP,
                    MIPS_SW_OP:    w_next_state = MEMADR;
                    MIPS_RTYPE_OP: w_next_state = EXECUTE;
                    MIPS_BEQ_OP:   w_next_state = BRANCH;
                    MIPS_ADDI_OP:  w_next_state = ADDIEXEC;
                    MIPS_J_OP:     w_next_state = JUMP;
                    default:       w_next_state = FETCH;
                endcase
            end
            MEMADR: begin
                if (opcode == MIPS_SW_OP) begin
                    w_next_state = MEMWR;
                end else if (opcode == MIPS_LW_OP) begin
                    w_next_state = MEMRD;
                end else begin
                    w_next_state = FETCH;
                end
            end
            MEMRD:    w_next_state = mem_ready ? MEMWB : MEMRD;
            MEMWB:    w_next_state = FETCH;
            MEMWR:    w_next_state = mem_ready ? FETCH : MEMWR;
            EXECUTE:  w_next_state = ALUWB;
            ALUWB:    w_next_state = FETCH;
            BRANCH:   w_next_state = FETCH;
            ADDIEXEC: w_next_state = ADDIWB;
            ADDIWB:   w_next_state = FETCH;
            JUMP:     w_next_state = FETCH;
            default:  w_next_state = FETCH;
        endcase
    end

    // Output decode; everything defaults to 0 so unused encodings are inert.
    always_comb begin
        iord           = 1'b0;
        w_mem_write    = 1'b0;
        w_ir_write     = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        w_reg_write    = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = SRCB_REG;
        alu_op         = ALU_OP_ADD;
        pc_src         = PC_SRC_ALU;
        w_pc_write_int = 1'b0;
        w_branch_int   = 1'b0;
        w_illegal_op   = 1'b0;
        case (r_state)
            FETCH: begin
                alu_src_b      = SRCB_FOUR;
                w_ir_write     = mem_ready;
                w_pc_write_int = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    MIPS_LW_OP, MIPS_SW_OP, MIPS_RTYPE_OP,
                    MIPS_BEQ_OP, MIPS_ADDI_OP, MIPS_J_OP: w_illegal_op = 1'b0;
                    default:                              w_illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
            end
            MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            ALUWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = ALU_OP_SUB;
                pc_src       = PC_SRC_ALUOUT;
                w_branch_int = 1'b1;
            end
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ADDIWB: begin
                w_reg_write = 1'b1;
            end
            JUMP: begin
                pc_src         = PC_SRC_JUMP;
                w_pc_write_int = 1'b1;
            end
            default: begin
                iord = 1'b0;
            end
        endcase
    end

    // Enables are forced low while reset is asserted, independent of state.
    assign mem_write  = rst_n & w_mem_write;
    assign ir_write   = rst_n & w_ir_write;
    assign reg_write  = rst_n & w_reg_write;
    assign pc_en      = rst_n & (w_pc_write_int | (w_branch_int & zero));
    assign illegal_op = rst_n & w_illegal_op;

    // Retired-instruction counter: one count per IR load, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (ir_write) begin
            r_instr_count <= r_instr_count + CNT_ONE;
        end
    end

    assign state_o     = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_main_ctrl_fsm.sv
// Bench for mips_main_ctrl_fsm. The reference model is instruction-level:
// each opcode expands to its path of states, wait states repeat while
// mem_ready is low, and each state's control word comes from a lookup table.
// A narrow counter width makes the instr_count wrap reachable.
module tb_mips_main_ctrl_fsm;
  import MIPS_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic             alu_src_a, pc_en, illegal_op;
  logic [1:0]       alu_src_b, alu_op, pc_src;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_cnt;

  // Observations gathered over the most recent run_instr call.
  int obs_cycles, obs_mem_write, obs_reg_write, obs_mem_to_reg, obs_illegal;
  int obs_br_taken, obs_funct, obs_rd_write;

  mips_main_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_op(illegal_op), .state_o(state_o), .instr_count(instr_count)
  );

  // Clock
  always #5 clk = ~clk;

  // Control word: iord mem_write ir_write reg_dst mem_to_reg reg_write
  //               alu_src_a alu_src_b[2] alu_op[2] pc_src[2] pc_en illegal_op
  function automatic logic [14:0] exp_ctrl(ctrl_state_e st, logic mr, logic z, logic legal);
    logic io, mw, ir, rd, m2r, rw, sa, pe, il;
    logic [1:0] sb, ao, ps;
    {io, mw, ir, rd, m2r, rw, sa, pe, il} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      FETCH:    begin sb = 2'b01; ir = mr; pe = mr; end
      DECODE:   begin sb = 2'b11; il = !legal; end
      MEMADR:   begin sa = 1'b1; sb = 2'b10; end
      MEMRD:    begin io = 1'b1; end
      MEMWB:    begin m2r = 1'b1; rw = 1'b1; end
      MEMWR:    begin io = 1'b1; mw = 1'b1; end
      EXECUTE:  begin sa = 1'b1; ao = 2'b10; end
      ALUWB:    begin rd = 1'b1; rw = 1'b1; end
      BRANCH:   begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = z; end
      ADDIEXEC: begin sa = 1'b1; sb = 2'b10; end
      ADDIWB:   begin rw = 1'b1; end
      JUMP:     begin ps = 2'b10; pe = 1'b1; end
      default:  begin io = 1'b0; end
    endcase
    return {io, mw, ir, rd, m2r, rw, sa, sb, ao, ps, pe, il};
  endfunction

  // Runs one instruction from FETCH. fw/mw: mem_ready-low cycles in FETCH and
  // in the memory access state (-1 = random).
  task automatic run_instr(input logic [5:0] op, input logic zero_v, input int fw, input int mw);
    ctrl_state_e path[$];
    ctrl_state_e st;
    int fw_t, mw_t, waits;
    logic mr, stall, legal;
    logic [14:0] e, a;
    fw_t = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
    mw_t = (mw < 0) ? int'($urandom_range(0, 3)) : mw;
    legal = 1'b1;
    path.push_back(FETCH);
    path.push_back(DECODE);
    case (op)
      6'h23: begin path.push_back(MEMADR); path.push_back(MEMRD); path.push_back(MEMWB); end
      6'h2B: begin path.push_back(MEMADR); path.push_back(MEMWR); end
      6'h00: begin path.push_back(EXECUTE); path.push_back(ALUWB); end
      6'h04: path.push_back(BRANCH);
      6'h08: begin path.push_back(ADDIEXEC); path.push_back(ADDIWB); end
      6'h02: path.push_back(JUMP);
      default: legal = 1'b0;
    endcase
    {obs_cycles, obs_mem_write, obs_reg_write, obs_mem_to_reg} = '0;
    {obs_illegal, obs_br_taken, obs_funct, obs_rd_write} = '0;
    foreach (path[i]) begin
      st = path[i];
      waits = 0;
      do begin
        @(negedge clk);
        if (st == FETCH) mr = (waits >= fw_t);
        else if (st == MEMRD || st == MEMWR) mr = (waits >= mw_t);
        else mr = 1'($urandom_range(0, 1));
        mem_ready = mr;
        zero   = (st == BRANCH) ? zero_v : 1'($urandom_range(0, 1));
        opcode = (st == DECODE || st == MEMADR) ? op : 6'($urandom_range(0, 63));
        #1;
        n_tests++;
        if (state_o !== st) begin
          n_fail++;
          $display("FAIL state op=%h: got %0d expected %0d", op, state_o, st);
        end
        e = exp_ctrl(st, mr, zero, legal);
        a = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL ctrl op=%h st=%0d: got %b expected %b", op, st, a, e);
        end
        n_tests++;
        if (instr_count !== exp_cnt) begin
          n_fail++;
          $display("FAIL instr_count: got %0d expected %0d", instr_count, exp_cnt);
        end
        obs_cycles++;
        if (mem_write) obs_mem_write++;
        if (reg_write) obs_reg_write++;
        if (mem_to_reg) obs_mem_to_reg++;
        if (illegal_op) obs_illegal++;
        if (pc_en && pc_src == 2'b01) obs_br_taken++;
        if (alu_op == 2'b10) obs_funct++;
        if (reg_write && reg_dst) obs_rd_write++;
        if (st == FETCH && mr) exp_cnt = exp_cnt + 1'b1;
        stall = (st == FETCH || st == MEMRD || st == MEMWR) && !mr;
        waits++;
      end while (stall);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_held_reset(input string name);
    n_tests++;
    if (state_o !== FETCH || {mem_write, ir_write, reg_write, pc_en, illegal_op} !== 5'b0 ||
        instr_count !== '0) begin
      n_fail++;
      $display("FAIL %s: got state=%0d en=%b cnt=%0d expected state=0 en=00000 cnt=0", name,
               state_o, {mem_write, ir_write, reg_write, pc_en, illegal_op}, instr_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h23; zero = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_held_reset("reset");
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_lw();
    run_instr(6'h23, 1'b0, 0, 0);
    check_int("lw_cycles", obs_cycles, 5);
    check_int("lw_reg_write", obs_reg_write, 1);
    check_int("lw_mem_to_reg", obs_mem_to_reg, 1);
    check_int("lw_instr_count", int'(instr_count), 1);
  endtask

  task automatic test_rtype();
    run_instr(6'h00, 1'b0, 0, 0);
    check_int("rtype_cycles", obs_cycles, 4);
    check_int("rtype_funct", obs_funct, 1);
    check_int("rtype_rd_write", obs_rd_write, 1);
  endtask

  task automatic test_beq();
    run_instr(6'h04, 1'b1, 0, 0);
    check_int("beq_taken", obs_br_taken, 1);
    run_instr(6'h04, 1'b0, 0, 0);
    check_int("beq_not_taken", obs_br_taken, 0);
  endtask

  task automatic test_sw_wait();
    run_instr(6'h2B, 1'b0, 0, 3);
    check_int("sw_mem_write_cycles", obs_mem_write, 4);
    check_int("sw_cycles", obs_cycles, 7);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_int("sw_back_to_fetch", int'(state_o), int'(FETCH));
    check_int("sw_fetch_ir_write", int'(ir_write), 0);
  endtask

  task automatic test_fetch_stall();
    run_instr(6'h02, 1'b0, 5, 0);
    check_int("stall_cycles", obs_cycles, 8);
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 1'b0, 0, 0);
    check_int("illegal_pulses", obs_illegal, 1);
    check_int("illegal_cycles", obs_cycles, 2);
  endtask

  task automatic test_reset_mid_addi();
    @(negedge clk);
    mem_ready = 1'b1; opcode = 6'h08;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_int("addi_reached", int'(state_o), int'(ADDIEXEC));
    #2 rst_n = 1'b0;
    #1 check_held_reset("reset_mid_addi");
    @(negedge clk);
    #1 check_held_reset("reset_mid_addi_held");
    mem_ready = 1'b0;
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F};
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0)
        run_instr(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), -1, -1);
      else
        run_instr(ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)), -1, -1);
    end
  endtask

  initial begin
    exp_cnt = '0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_wait();
    test_fetch_stall();
    test_illegal();
    test_reset_mid_addi();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
